// File: rtl/rout_mc_if.sv
// rout_mc_if: router-side bundle of arbitration inputs, master W channel and routing outputs
interface rout_mc_if #(
  parameter int NUM_CH = 4,
  parameter int USER_W = 2,
  parameter int BEAT_W = 8
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic                     proc_full;
  logic                     proc_empty;
  logic                     block_fin;
  logic [NUM_CH-1:0]        spec2router;
  logic [2*NUM_CH-1:0]      unluck;
  logic [NUM_CH-1:0]        s_awvalid;
  logic [NUM_CH*USER_W-1:0] s_awuser;
  logic [USER_W-1:0]        m_awuser;
  logic                     wvalid;
  logic                     wready;
  logic                     wlast;
  logic [2:0]               routers_ps;
  logic [NUM_CH-1:0]        grant;
  logic [CH_W-1:0]          grant_idx;
  logic [BEAT_W-1:0]        beat_cnt;
  logic                     block_timeout;
  modport slave (
    input  proc_full, proc_empty, block_fin, spec2router, unluck, s_awvalid, s_awuser,
           m_awuser, wvalid, wready, wlast,
    output routers_ps, grant, grant_idx, beat_cnt, block_timeout
  );
  modport master (
    output proc_full, proc_empty, block_fin, spec2router, unluck, s_awvalid, s_awuser,
           m_awuser, wvalid, wready, wlast,
    input  routers_ps, grant, grant_idx, beat_cnt, block_timeout
  );
endinterface

// File: rtl/rout_mc.sv
// rout_mc: multi-channel write-path router FSM (optional BLOCKED timeout via ROUT_BLOCK_TIMEOUT_EN)
module rout_mc #(
  parameter int                NUM_CH      = 4,
  parameter int                USER_W      = 2,
  parameter logic [USER_W-1:0] BLOCK_CODE  = USER_W'(1),
  parameter logic [USER_W-1:0] DIVERT_CODE = USER_W'(2),
  parameter int                BEAT_W      = 8,
  parameter int                TMO_CYCLES  = 1024
) (
  input logic    clk,
  input logic    rst,
  rout_mc_if.slave bus
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic [2:0] {
    IDLE     = 3'b111,
    REG_FLOW = 3'b000,
    BLOCKED  = 3'b001,
    MERGE    = 3'b010
  } state_e;
  state_e              state_q;
  logic [NUM_CH-1:0]   grant_q;
  logic [CH_W-1:0]     idx_q;
  logic [CH_W-1:0]     rr_q;
  logic [BEAT_W-1:0]   cnt_q;
  logic                tmo_pulse_q;
  logic [NUM_CH-1:0]   reg_ok;
  logic [NUM_CH-1:0]   merge_ok;
  logic                reg_hit;
  logic                merge_hit;
  logic [CH_W-1:0]     reg_idx;
  logic [CH_W-1:0]     merge_idx;
  logic [CH_W-1:0]     c;
  logic [CH_W-1:0]     sel;
  logic [CH_W-1:0]     rr_d;
  logic                beat;
  logic                last;
  logic                is_blk;
  logic                tmo_hit;
  assign beat   = bus.wvalid && bus.wready;
  assign last   = beat && bus.wlast;
  assign is_blk = bus.m_awuser == BLOCK_CODE;
  assign sel    = reg_hit ? reg_idx : merge_idx;
  assign rr_d   = CH_W'((int'(sel) + 1) % NUM_CH);
`ifdef ROUT_BLOCK_TIMEOUT_EN
  localparam int TMO_W = TMO_CYCLES > 1 ? $clog2(TMO_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_q;
  assign tmo_hit = tmo_q == TMO_W'(TMO_CYCLES - 1);
  // BLOCKED dwell counter; zero outside BLOCKED so every entry starts from 0
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else tmo_q <= (state_q == BLOCKED && !tmo_hit) ? tmo_q + 1'b1 : '0;
  end
`else
  logic unused_tmo;
  assign unused_tmo = |TMO_CYCLES;
  assign tmo_hit    = 1'b0;
`endif
  // per-channel qualification and round-robin search starting at rr_q
  always_comb begin
    reg_ok    = '0;
    merge_ok  = '0;
    reg_hit   = 1'b0;
    merge_hit = 1'b0;
    reg_idx   = '0;
    merge_idx = '0;
    c         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      reg_ok[i]   = (bus.unluck[2*i +: 2] == 2'b10 && bus.s_awuser[i*USER_W +: USER_W] != DIVERT_CODE) ||
                    (bus.proc_empty && bus.s_awvalid[i] && !bus.proc_full);
      merge_ok[i] = bus.spec2router[i] && !bus.proc_full;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      c = CH_W'((int'(rr_q) + k) % NUM_CH);
      if (!reg_hit && reg_ok[c]) begin
        reg_hit = 1'b1;
        reg_idx = c;
      end
      if (!merge_hit && merge_ok[c]) begin
        merge_hit = 1'b1;
        merge_idx = c;
      end
    end
  end
  // routing FSM with registered grant, beat counter and timeout pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      idx_q       <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      tmo_pulse_q <= 1'b0;
    end else begin
      tmo_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (reg_hit || merge_hit) begin
            state_q <= reg_hit ? REG_FLOW : MERGE;
            grant_q <= NUM_CH'(1) << sel;
            idx_q   <= sel;
            rr_q    <= rr_d;
          end
        end
        REG_FLOW, MERGE: begin
          cnt_q <= last ? '0 : (beat && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
          if (last) begin
            if (is_blk) state_q <= BLOCKED;
            else if (merge_ok[idx_q]) state_q <= MERGE;
            else begin
              state_q <= IDLE;
              grant_q <= '0;
              idx_q   <= '0;
            end
          end
        end
        BLOCKED: begin
          cnt_q <= '0;
          if (bus.block_fin || tmo_hit) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            idx_q       <= '0;
            tmo_pulse_q <= !bus.block_fin;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          idx_q   <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end
  assign bus.routers_ps    = state_q;
  assign bus.grant         = grant_q;
  assign bus.grant_idx     = idx_q;
  assign bus.beat_cnt      = cnt_q;
  assign bus.block_timeout = tmo_pulse_q;
endmodule

// File: tb/tb_rout_mc.sv
// tb_rout_mc: scoreboard-driven scenario bench for rout_mc
module tb_rout_mc;
  localparam logic [2:0] IDLE = 3'b111, REG = 3'b000, BLK = 3'b001, MRG = 3'b010;
  localparam logic [1:0] BLOCK_C = 2'b01, DIVERT_C = 2'b10;
  typedef struct packed {
    logic [2:0] ps;
    logic [3:0] g;
    logic [1:0] gi;
    logic [7:0] bc;
    logic       to;
  } obs_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  obs_t exp_q[$];
  obs_t got, e;
  rout_mc_if #(.NUM_CH(4), .USER_W(2), .BEAT_W(8)) bus ();
  rout_mc #(
    .NUM_CH(4), .USER_W(2), .BLOCK_CODE(BLOCK_C), .DIVERT_CODE(DIVERT_C), .BEAT_W(8), .TMO_CYCLES(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic obs_t mk(logic [2:0] ps, logic [3:0] g, logic [1:0] gi, logic [7:0] bc);
    return '{ps: ps, g: g, gi: gi, bc: bc, to: 1'b0};
  endfunction
  function automatic obs_t sample();
    return '{ps: bus.routers_ps, g: bus.grant, gi: bus.grant_idx, bc: bus.beat_cnt, to: bus.block_timeout};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic w(logic v, logic r, logic l);
    bus.wvalid = v;
    bus.wready = r;
    bus.wlast  = l;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(mk(IDLE, 4'b0000, 2'd0, 8'd0));
      tick();
      got = sample(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL reset_hold[%0d] got=%h exp=%h", i, got, e); end
    end
    rst = 1'b0;
    bus.s_awvalid = 4'b0100;
    bus.proc_empty = 1'b1;
    exp_q.push_back(mk(REG, 4'b0100, 2'd2, 8'd0));
    tick();
    got = sample(); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL reset_release_grant got=%h exp=%h", got, e); end
    bus.s_awvalid = 4'b0000;
    w(1, 1, 1);
    exp_q.push_back(mk(IDLE, 4'b0000, 2'd0, 8'd0));
    tick();
    w(0, 0, 0);
    got = sample(); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL reset_first_last got=%h exp=%h", got, e); end
  endtask
  task automatic test_round_robin();
    bus.unluck = 8'b0000_0010;
    bus.s_awuser = {6'b0, DIVERT_C};
    exp_q.push_back(mk(IDLE, 4'b0000, 2'd0, 8'd0));
    tick();
    got = sample(); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL rr_divert_excluded got=%h exp=%h", got, e); end
    bus.unluck = 8'b0000_1000;
    bus.s_awuser = '0;
    exp_q.push_back(mk(REG, 4'b0010, 2'd1, 8'd0));
    tick();
    bus.unluck = '0;
    got = sample(); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL rr_unluck_grant got=%h exp=%h", got, e); end
    w(1, 1, 1);
    tick();
    w(0, 0, 0);
    bus.s_awvalid = 4'b1010;
    exp_q.push_back(mk(REG, 4'b1000, 2'd3, 8'd0));
    exp_q.push_back(mk(IDLE, 4'b0000, 2'd0, 8'd0));
    exp_q.push_back(mk(REG, 4'b0010, 2'd1, 8'd0));
    for (int i = 0; i < 3; i++) begin
      w(i == 1, i == 1, i == 1);
      tick();
      got = sample(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL rr_pair_step%0d got=%h exp=%h", i, got, e); end
    end
    bus.s_awvalid = '0;
    w(1, 1, 1);
    tick();
    w(0, 0, 0);
  endtask
  task automatic test_block();
    bus.s_awvalid = 4'b0001;
    exp_q.push_back(mk(REG, 4'b0001, 2'd0, 8'd0));
    for (int b = 1; b <= 3; b++) exp_q.push_back(mk(REG, 4'b0001, 2'd0, 8'(b)));
    exp_q.push_back(mk(BLK, 4'b0001, 2'd0, 8'd0));
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        bus.m_awuser = BLOCK_C;
        bus.spec2router = 4'b0001;
      end
      w(i > 0, i > 0, i == 4);
      tick();
      bus.s_awvalid = '0;
      got = sample(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL block_burst_step%0d got=%h exp=%h", i, got, e); end
    end
    bus.m_awuser = '0;
    bus.spec2router = '0;
    for (int i = 0; i < 5; i++) begin
      w(1, 1, i[0]);
      bus.block_fin = i == 4;
      exp_q.push_back(i == 4 ? mk(IDLE, 4'b0000, 2'd0, 8'd0) : mk(BLK, 4'b0001, 2'd0, 8'd0));
      tick();
      got = sample(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL block_wait_step%0d got=%h exp=%h", i, got, e); end
    end
    bus.block_fin = 1'b0;
    w(0, 0, 0);
  endtask
  task automatic test_merge();
    bus.spec2router = 4'b0010;
    exp_q.push_back(mk(MRG, 4'b0010, 2'd1, 8'd0));
    exp_q.push_back(mk(MRG, 4'b0010, 2'd1, 8'd1));
    exp_q.push_back(mk(MRG, 4'b0010, 2'd1, 8'd0));
    exp_q.push_back(mk(MRG, 4'b0010, 2'd1, 8'd0));
    exp_q.push_back(mk(MRG, 4'b0010, 2'd1, 8'd1));
    exp_q.push_back(mk(MRG, 4'b0010, 2'd1, 8'd2));
    exp_q.push_back(mk(IDLE, 4'b0000, 2'd0, 8'd0));
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: w(0, 0, 0);
        1: w(1, 1, 0);
        2: w(1, 1, 1);
        3: w(1, 0, 1);
        4: w(1, 1, 0);
        5: begin w(1, 1, 0); bus.proc_full = 1'b1; end
        default: begin w(1, 1, 1); bus.proc_full = 1'b0; bus.spec2router = '0; end
      endcase
      tick();
      got = sample(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL merge_step%0d got=%h exp=%h", i, got, e); end
    end
    w(0, 0, 0);
  endtask
  task automatic test_saturate();
    bus.s_awvalid = 4'b0100;
    tick();
    bus.s_awvalid = '0;
    w(1, 1, 0);
    for (int i = 1; i <= 300; i++) begin
      if (i == 255 || i == 300) exp_q.push_back(mk(REG, 4'b0100, 2'd2, 8'(i > 255 ? 255 : i)));
      tick();
      if (i == 255 || i == 300) begin
        got = sample(); e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_err++; $display("FAIL saturate_beat%0d got=%h exp=%h", i, got, e); end
      end
    end
    w(1, 1, 1);
    exp_q.push_back(mk(IDLE, 4'b0000, 2'd0, 8'd0));
    tick();
    w(0, 0, 0);
    got = sample(); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL saturate_clear got=%h exp=%h", got, e); end
  endtask
  task automatic test_block_hold();
    bus.s_awvalid = 4'b1000;
    tick();
    bus.s_awvalid = '0;
    bus.m_awuser = BLOCK_C;
    w(1, 1, 1);
    tick();
    w(0, 0, 0);
    bus.m_awuser = '0;
    for (int i = 0; i < 100; i++) begin
      exp_q.push_back(mk(BLK, 4'b1000, 2'd3, 8'd0));
      tick();
      got = sample(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL block_hold_cycle%0d got=%h exp=%h", i, got, e); end
    end
    bus.block_fin = 1'b1;
    exp_q.push_back(mk(IDLE, 4'b0000, 2'd0, 8'd0));
    tick();
    bus.block_fin = 1'b0;
    got = sample(); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL block_hold_release got=%h exp=%h", got, e); end
  endtask
  task automatic test_reset_mid_burst();
    bus.spec2router = 4'b0100;
    exp_q.push_back(mk(MRG, 4'b0100, 2'd2, 8'd0));
    exp_q.push_back(mk(MRG, 4'b0100, 2'd2, 8'd1));
    exp_q.push_back(mk(MRG, 4'b0100, 2'd2, 8'd2));
    exp_q.push_back(mk(IDLE, 4'b0000, 2'd0, 8'd0));
    exp_q.push_back(mk(REG, 4'b0010, 2'd1, 8'd0));
    for (int i = 0; i < 5; i++) begin
      w(i > 0 && i < 4, i > 0 && i < 4, 0);
      rst = i == 3;
      if (i == 4) begin
        bus.spec2router = '0;
        bus.s_awvalid = 4'b1010;
      end
      tick();
      got = sample(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL reset_mid_step%0d got=%h exp=%h", i, got, e); end
    end
    rst = 1'b0;
    bus.s_awvalid = '0;
  endtask
  initial begin
    bus.proc_full = 1'b0;
    bus.proc_empty = 1'b0;
    bus.block_fin = 1'b0;
    bus.spec2router = '0;
    bus.unluck = '0;
    bus.s_awvalid = '0;
    bus.s_awuser = '0;
    bus.m_awuser = '0;
    w(0, 0, 0);
    test_reset();
    test_round_robin();
    test_block();
    test_merge();
    test_saturate();
    test_block_hold();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
